// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared FIFO definitions: depth/count-width helpers and default flag margins.
// Imported by the controller, its interface and the bench.
package sync_fifo_ctrl_pkg;

  localparam int ASIZE_DEF     = 4;
  localparam int AF_MARGIN_DEF = 2;
  localparam int AE_MARGIN_DEF = 2;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  // One extra bit distinguishes full from empty when the address bits match.
  function automatic int count_w(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle between producer/consumer logic, the FIFO
// controller and the storage array.
interface sync_fifo_ctrl_if
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF
);

  logic                        w_en;
  logic                        r_en;
  logic                        flush;
  logic [ASIZE-1:0]            waddr;
  logic [ASIZE-1:0]            raddr;
  logic                        mem_we;
  logic                        wfull;
  logic                        rempty;
  logic [count_w(ASIZE)-1:0]   count;
  logic                        almost_full;
  logic                        almost_empty;
  logic                        overflow;
  logic                        underflow;

  modport master (
    output w_en, r_en, flush,
    input  waddr, raddr, mem_we, wfull, rempty, count,
    input  almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, flush,
    output waddr, raddr, mem_we, wfull, rempty, count,
    output almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary read/write pointers with an extra wrap
// bit, status flags decoded from the registered pointers, sticky error flags.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ASIZE     = ASIZE_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF,
  parameter int AE_MARGIN = AE_MARGIN_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sync_fifo_ctrl_if.slave  bus
);

  localparam int CW    = count_w(ASIZE);
  localparam int DEPTH = depth_of(ASIZE);
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          empty, full, wr_acc, rd_acc;
  logic [CW-1:0] occ;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                  (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
  assign occ    = wptr_q - rptr_q;
  assign wr_acc = bus.w_en & ~full;
  assign rd_acc = bus.r_en & ~empty;

  // Flush behaves like reset on all state and wins over any request that cycle.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ONE;
      if (rd_acc) rptr_d = rptr_q + ONE;
      overflow_d  = overflow_q  | (bus.w_en & full);
      underflow_d = underflow_q | (bus.r_en & empty);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.waddr        = wptr_q[ASIZE-1:0];
  assign bus.raddr        = rptr_q[ASIZE-1:0];
  assign bus.mem_we       = bus.w_en & ~full & ~bus.flush;
  assign bus.wfull        = full;
  assign bus.rempty       = empty;
  assign bus.count        = occ;
  assign bus.almost_full  = (occ >= AF_LEVEL);
  assign bus.almost_empty = (occ <= AE_LEVEL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
